ped_request_conditioner: RTL and testbench
==========================================

// Module: ped_request_conditioner
// PURPOSE
//  Upstream stage of traffic_light_controller. Synchronises and debounces the raw pedestrian
//  push-button, then latches one request. Drives the controller's ped_req input and holds it
//  until the controller answers with ped_walk. Merges repeated presses and drops presses made
//  while a walk phase is already being served.
// PARAMETERS
//  DEBOUNCE_CYCLES  4   consecutive stable clocks at the sync output needed to change btn_clean (>=1)
//  CNT_W            8   width of press_count (saturating)
//  LOCKOUT_CYCLES   16  post-walk lockout length in clocks; used only with PED_LOCKOUT_EN
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  reset        in   1      synchronous, active-high reset
//  btn_raw      in   1      asynchronous, bouncy push-button level, active-high
//  ped_walk     in   1      from traffic_light_controller: walk phase active
//  ped_req      out  1      to traffic_light_controller: registered level, request pending
//  btn_clean    out  1      debounced button level (status/debug)
//  press_count  out  CNT_W  count of accepted requests, saturates at all-ones
// BEHAVIOUR
//  Reset: all flops 0. ped_req=0, btn_clean=0, press_count=0, state=IDLE, debounce counter=0.
//  Sync: 2-flop synchroniser on btn_raw, output s.
//  Debounce: if s==btn_clean then cnt<=0. Otherwise cnt increments; when cnt==DEBOUNCE_CYCLES-1,
//   btn_clean<=s and cnt<=0.
//   btn_clean follows a stable change DEBOUNCE_CYCLES+2 clocks after the first edge that samples it.
//  press_evt = btn_clean & ~btn_clean_d (combinational, one cycle wide). Only rising edges count.
//  FSM (registered), ped_req = (state==PENDING):
//   IDLE    press_evt & ~ped_walk -> PENDING, press_count++ (sat). ped_req is high the next clock.
//           press_evt & ped_walk -> SERVING; no request is raised and no count is taken.
//   PENDING ped_walk -> SERVING, so ped_req falls the clock after ped_walk is first sampled high.
//           Further press_evt is merged: no count.
//   SERVING ~ped_walk -> IDLE (or LOCKOUT, see CONFIGURATION). press_evt is ignored.
//   LOCKOUT down-counter from LOCKOUT_CYCLES-1; at 0 -> IDLE. press_evt is discarded.
//  Simultaneous press_evt and ped_walk in PENDING: go to SERVING; no count.
//  press_count saturates and never wraps.
//  Button held across reset: after release it yields exactly one press, DEBOUNCE_CYCLES+2 clocks
//   after the first post-reset edge.
//  Reset mid-operation: everything returns to the reset values on the next clock edge, regardless of state.
//  End-to-end: btn_raw rise to ped_req rise = DEBOUNCE_CYCLES+3 clocks.
// CONFIGURATION
//  PED_LOCKOUT_EN defined: the SERVING exit goes to LOCKOUT for LOCKOUT_CYCLES clocks, then IDLE.
//  PED_LOCKOUT_EN undefined: the SERVING exit goes straight to IDLE. The LOCKOUT state and its
//   counter are not built, and LOCKOUT_CYCLES is ignored.
// STRUCTURE
//  Shared package traffic_pkg holds the state encodings as 2-bit localparams:
//   PR_IDLE=0, PR_PENDING=1, PR_SERVING=2, PR_LOCKOUT=3.
//   The controller's phase constants also live in traffic_pkg.
//  One sub-module, btn_debouncer (ports clk, reset, btn_raw, btn_clean, press_evt):
//   synchroniser, debounce counter and edge detect.
//  The top level holds the FSM, press_count and the lockout counter.
// TESTING (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=16, CNT_W=8)
//  1 btn_raw=1 held through 3-cycle reset, released -> ped_req=1 exactly 7 clocks after release edge; press_count=1
//  2 btn_raw glitch high 3 clocks then low -> btn_clean stays 0, ped_req stays 0, press_count 0
//  3 clean press, ped_walk=1 at 10 clocks later -> ped_req falls next clock; ped_walk low after 8 -> IDLE
//  4 second press during PENDING and a third during SERVING -> press_count stays 1, no new ped_req
//  5 with PED_LOCKOUT_EN: press landing 5 clocks after ped_walk falls -> ignored; press landing 20 clocks after -> accepted.
//    without the macro: press landing 5 clocks after -> ped_req raised
//  6 reset asserted while PENDING -> ped_req=0, press_count=0 after that edge; 256 presses -> press_count=255

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared constants for the traffic-light controller and its
// pedestrian request conditioner (request-FSM state encodings, controller phases).
package traffic_pkg;

    // Pedestrian request conditioner state encodings
    localparam logic [1:0] PR_IDLE    = 2'd0;
    localparam logic [1:0] PR_PENDING = 2'd1;
    localparam logic [1:0] PR_SERVING = 2'd2;
    localparam logic [1:0] PR_LOCKOUT = 2'd3;

    // Controller phase encodings
    localparam logic [1:0] PH_NS_GREEN  = 2'd0;
    localparam logic [1:0] PH_NS_YELLOW = 2'd1;
    localparam logic [1:0] PH_EW_GREEN  = 2'd2;
    localparam logic [1:0] PH_EW_YELLOW = 2'd3;

endpackage

// File: rtl/btn_debouncer.sv
// btn_debouncer: two-flop synchroniser on the raw push-button, a stability
// counter that only lets btn_clean change after DEBOUNCE_CYCLES consecutive
// clocks of disagreement, and a one-cycle rising-edge pulse (press_evt).
module btn_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_clean,
    output logic press_evt
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ZERO = DB_W'(0);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

    logic            sync_meta;
    logic            sync_out;
    logic [DB_W-1:0] db_cnt;
    logic            btn_clean_d;

    // Bring the asynchronous button level into the clock domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= btn_raw;
            sync_out  <= sync_meta;
        end
    end

    // Accept a new level only after it has disagreed with btn_clean for DEBOUNCE_CYCLES clocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt    <= DB_ZERO;
            btn_clean <= 1'b0;
        end else if (sync_out == btn_clean) begin
            db_cnt    <= DB_ZERO;
            btn_clean <= btn_clean;
        end else if (db_cnt == DB_LAST) begin
            db_cnt    <= DB_ZERO;
            btn_clean <= sync_out;
        end else begin
            db_cnt    <= db_cnt + DB_ONE;
            btn_clean <= btn_clean;
        end
    end

    // Delayed copy of the clean level for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_clean_d <= 1'b0;
        end else begin
            btn_clean_d <= btn_clean;
        end
    end

    // Only presses (rising edges) are of interest; releases are ignored.
    assign press_evt = btn_clean & ~btn_clean_d;

endmodule

// File: rtl/ped_request_conditioner.sv
// ped_request_conditioner: debounces the pedestrian button and holds a single
// request (ped_req) towards traffic_light_controller until ped_walk answers it.
// Repeated presses merge; presses during a walk phase are dropped.
// Optional feature macro PED_LOCKOUT_EN: after a walk phase ends, presses are
// discarded for LOCKOUT_CYCLES clocks before the block returns to idle.
module ped_request_conditioner
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8,
    parameter int LOCKOUT_CYCLES  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_raw,
    input  logic             ped_walk,
    output logic             ped_req,
    output logic             btn_clean,
    output logic [CNT_W-1:0] press_count
);

    typedef enum logic [1:0] {
        S_IDLE    = PR_IDLE,
        S_PENDING = PR_PENDING,
        S_SERVING = PR_SERVING,
        S_LOCKOUT = PR_LOCKOUT
    } pr_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Out-of-range parameters are rejected at elaboration.
    if (DEBOUNCE_CYCLES < 1 || CNT_W < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_params
        $error("ped_request_conditioner: parameters must all be >= 1");
    end

    pr_state_t        state;
    pr_state_t        state_nx;
    logic [CNT_W-1:0] count_nx;
    logic             press_evt;

    // Saturating increment: the accepted-press count never wraps.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    btn_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .btn_clean(btn_clean),
        .press_evt(press_evt)
    );

`ifdef PED_LOCKOUT_EN
    localparam int LK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [LK_W-1:0] LK_ZERO = LK_W'(0);
    localparam logic [LK_W-1:0] LK_ONE  = LK_W'(1);

    logic [LK_W-1:0] lock_cnt;

    // Load the lockout window when the walk phase ends, then count it down to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_cnt <= LK_ZERO;
        end else if ((state == S_SERVING) && !ped_walk) begin
            lock_cnt <= LK_LAST;
        end else if ((state == S_LOCKOUT) && (lock_cnt != LK_ZERO)) begin
            lock_cnt <= lock_cnt - LK_ONE;
        end else begin
            lock_cnt <= lock_cnt;
        end
    end
`endif

    // Next-state and count logic for the request FSM.
    always_comb begin
        state_nx = state;
        count_nx = press_count;
        case (state)
            S_IDLE: begin
                if (press_evt && ped_walk) begin
                    // Walk already running: this press is satisfied without a request.
                    state_nx = S_SERVING;
                end else if (press_evt) begin
                    state_nx = S_PENDING;
                    count_nx = sat_inc(press_count);
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_PENDING: begin
                // Further presses merge into the outstanding request.
                if (ped_walk) begin
                    state_nx = S_SERVING;
                end else begin
                    state_nx = S_PENDING;
                end
            end
            S_SERVING: begin
                if (!ped_walk) begin
`ifdef PED_LOCKOUT_EN
                    state_nx = S_LOCKOUT;
`else
                    state_nx = S_IDLE;
`endif
                end else begin
                    state_nx = S_SERVING;
                end
            end
            S_LOCKOUT: begin
`ifdef PED_LOCKOUT_EN
                if (lock_cnt == LK_ZERO) begin
                    state_nx = S_IDLE;
                end else begin
                    state_nx = S_LOCKOUT;
                end
`else
                state_nx = S_IDLE;
`endif
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State, registered request output and accepted-press counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            ped_req     <= 1'b0;
            press_count <= '0;
        end else begin
            state       <= state_nx;
            ped_req     <= (state_nx == S_PENDING);
            press_count <= count_nx;
        end
    end

endmodule

// File: tb/tb_ped_request_conditioner.sv
// tb_ped_request_conditioner: directed scenarios plus randomized button/walk
// traffic, each compared cycle by cycle with a behavioural model of the
// request conditioner (sample delay line, run-length debounce, request mode).
module tb_ped_request_conditioner;

    localparam int DB      = 4;
    localparam int CNT_W   = 8;
    localparam int LOCK    = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PED_LOCKOUT_EN
    localparam bit LOCKOUT_ON = 1'b1;
`else
    localparam bit LOCKOUT_ON = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             btn_raw;
    logic             ped_walk;
    logic             ped_req;
    logic             btn_clean;
    logic [CNT_W-1:0] press_count;

    int n_pass  = 0;
    int n_total = 0;

    ped_request_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (CNT_W),
        .LOCKOUT_CYCLES (LOCK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .ped_walk   (ped_walk),
        .ped_req    (ped_req),
        .btn_clean  (btn_clean),
        .press_count(press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_WAIT_WALK, M_WALKING, M_COOLDOWN} m_mode_t;
    typedef struct {bit btn; bit walk; int len;} phase_t;

    bit      sync_q[$];
    bit      m_clean;
    bit      m_clean_prev;
    int      m_run;
    m_mode_t m_mode;
    int      m_lock;
    int      m_count;
    bit      m_req;

    // Advance one clock: model sees the same inputs the DUT samples, outputs read #1 later.
    task automatic step();
        bit s;
        bit press;
        @(posedge clk);
        if (reset) begin
            sync_q       = '{1'b0, 1'b0};
            m_clean      = 1'b0;
            m_clean_prev = 1'b0;
            m_run        = 0;
            m_mode       = M_IDLE;
            m_lock       = 0;
            m_count      = 0;
        end else begin
            s = sync_q.pop_front();
            sync_q.push_back(btn_raw);
            press = m_clean && !m_clean_prev;
            m_clean_prev = m_clean;
            if (s != m_clean) begin
                m_run++;
                if (m_run == DB) begin
                    m_clean = s;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
            case (m_mode)
                M_IDLE: if (press) begin
                    if (ped_walk) m_mode = M_WALKING;
                    else begin
                        m_mode = M_WAIT_WALK;
                        if (m_count < CNT_MAX) m_count++;
                    end
                end
                M_WAIT_WALK: if (ped_walk) m_mode = M_WALKING;
                M_WALKING: if (!ped_walk) begin
                    if (LOCKOUT_ON) begin
                        m_mode = M_COOLDOWN;
                        m_lock = LOCK;
                    end else begin
                        m_mode = M_IDLE;
                    end
                end
                M_COOLDOWN: begin
                    m_lock--;
                    if (m_lock == 0) m_mode = M_IDLE;
                end
                default: m_mode = M_IDLE;
            endcase
        end
        m_req = (m_mode == M_WAIT_WALK);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; btn_raw = 1'b0; ped_walk = 1'b0;
        repeat (3) step();
        n_total++;
        if (ped_req !== 1'b0) $display("FAIL reset_ped_req got %0b want 0", ped_req);
        else n_pass++;
        n_total++;
        if (btn_clean !== 1'b0) $display("FAIL reset_btn_clean got %0b want 0", btn_clean);
        else n_pass++;
        n_total++;
        if (press_count !== 8'd0) $display("FAIL reset_press_count got %0d want 0", press_count);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_glitch();
        phase_t ph[2] = '{'{1'b1, 1'b0, 3}, '{1'b0, 1'b0, 12}};
        for (int p = 0; p < 2; p++) begin
            btn_raw = ph[p].btn; ped_walk = ph[p].walk;
            for (int i = 0; i < ph[p].len; i++) begin
                step();
                n_total++;
                if ({ped_req, btn_clean, press_count} !== {m_req, m_clean, CNT_W'(m_count)})
                    $display("FAIL glitch got req=%0b clean=%0b cnt=%0d want req=%0b clean=%0b cnt=%0d",
                             ped_req, btn_clean, press_count, m_req, m_clean, m_count);
                else n_pass++;
            end
        end
        n_total++;
        if ({ped_req, btn_clean, press_count} !== {1'b0, 1'b0, 8'd0})
            $display("FAIL glitch_final got req=%0b clean=%0b cnt=%0d want req=0 clean=0 cnt=0",
                     ped_req, btn_clean, press_count);
        else n_pass++;
    endtask

    task automatic test_held_through_reset();
        int first_k = -1;
        reset = 1'b1; btn_raw = 1'b1; ped_walk = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (ped_req === 1'b1 && first_k < 0) first_k = k;
            n_total++;
            if ({ped_req, btn_clean, press_count} !== {m_req, m_clean, CNT_W'(m_count)})
                $display("FAIL held_reset got req=%0b clean=%0b cnt=%0d want req=%0b clean=%0b cnt=%0d",
                         ped_req, btn_clean, press_count, m_req, m_clean, m_count);
            else n_pass++;
        end
        n_total++;
        if (first_k !== DB + 3) $display("FAIL held_reset_latency got %0d want %0d", first_k, DB + 3);
        else n_pass++;
        n_total++;
        if (press_count !== 8'd1) $display("FAIL held_reset_count got %0d want 1", press_count);
        else n_pass++;
        // release, serve the request and return to idle
        btn_raw = 1'b0;
        repeat (8) step();
        ped_walk = 1'b1;
        repeat (2) step();
        ped_walk = 1'b0;
        repeat (20) step();
    endtask

    task automatic test_serve();
        int cnt0 = m_count;
        btn_raw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 8) btn_raw = 1'b0;
            step();
            n_total++;
            if ({ped_req, btn_clean, press_count} !== {m_req, m_clean, CNT_W'(m_count)})
                $display("FAIL serve got req=%0b clean=%0b cnt=%0d want req=%0b clean=%0b cnt=%0d",
                         ped_req, btn_clean, press_count, m_req, m_clean, m_count);
            else n_pass++;
        end
        n_total++;
        if (ped_req !== 1'b1) $display("FAIL serve_req_high got %0b want 1", ped_req);
        else n_pass++;
        ped_walk = 1'b1;
        step();
        n_total++;
        if (ped_req !== 1'b0) $display("FAIL serve_req_fall got %0b want 0", ped_req);
        else n_pass++;
        repeat (7) step();
        ped_walk = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_total++;
            if ({ped_req, btn_clean, press_count} !== {m_req, m_clean, CNT_W'(m_count)})
                $display("FAIL serve_exit got req=%0b clean=%0b cnt=%0d want req=%0b clean=%0b cnt=%0d",
                         ped_req, btn_clean, press_count, m_req, m_clean, m_count);
            else n_pass++;
        end
        n_total++;
        if (press_count !== CNT_W'(cnt0 + 1)) $display("FAIL serve_count got %0d want %0d", press_count, cnt0 + 1);
        else n_pass++;
    endtask

    task automatic test_merge();
        int cnt0 = m_count;
        phase_t ph[8] = '{'{1'b1, 1'b0, 10}, '{1'b0, 1'b0, 8}, '{1'b1, 1'b0, 8}, '{1'b0, 1'b0, 8},
                          '{1'b0, 1'b1, 2},  '{1'b1, 1'b1, 8}, '{1'b0, 1'b1, 8}, '{1'b0, 1'b0, 25}};
        for (int p = 0; p < 8; p++) begin
            btn_raw = ph[p].btn; ped_walk = ph[p].walk;
            for (int i = 0; i < ph[p].len; i++) begin
                step();
                n_total++;
                if ({ped_req, btn_clean, press_count} !== {m_req, m_clean, CNT_W'(m_count)})
                    $display("FAIL merge got req=%0b clean=%0b cnt=%0d want req=%0b clean=%0b cnt=%0d",
                             ped_req, btn_clean, press_count, m_req, m_clean, m_count);
                else n_pass++;
            end
        end
        n_total++;
        if ({ped_req, press_count} !== {1'b0, CNT_W'(cnt0 + 1)})
            $display("FAIL merge_final got req=%0b cnt=%0d want req=0 cnt=%0d", ped_req, press_count, cnt0 + 1);
        else n_pass++;
    endtask

    task automatic test_lockout();
        // Part 1: a press landing 5 clocks after ped_walk falls.
        phase_t a[5] = '{'{1'b1, 1'b0, 8}, '{1'b1, 1'b1, 1}, '{1'b0, 1'b1, 8}, '{1'b1, 1'b1, 2}, '{1'b1, 1'b0, 10}};
        // Part 2: return to idle, then a press landing 20 clocks after ped_walk falls.
        phase_t b[8] = '{'{1'b0, 1'b1, 2}, '{1'b0, 1'b0, 30}, '{1'b1, 1'b0, 8}, '{1'b1, 1'b1, 1},
                         '{1'b0, 1'b1, 7}, '{1'b0, 1'b0, 13}, '{1'b1, 1'b0, 7}, '{1'b1, 1'b0, 3}};
        int cnt0;
        for (int p = 0; p < 5; p++) begin
            btn_raw = a[p].btn; ped_walk = a[p].walk;
            for (int i = 0; i < a[p].len; i++) begin
                step();
                n_total++;
                if ({ped_req, btn_clean, press_count} !== {m_req, m_clean, CNT_W'(m_count)})
                    $display("FAIL lockout_a got req=%0b clean=%0b cnt=%0d want req=%0b clean=%0b cnt=%0d",
                             ped_req, btn_clean, press_count, m_req, m_clean, m_count);
                else n_pass++;
            end
        end
        n_total++;
        if (ped_req !== !LOCKOUT_ON) $display("FAIL lockout_early_press got %0b want %0b", ped_req, !LOCKOUT_ON);
        else n_pass++;
        for (int p = 0; p < 8; p++) begin
            btn_raw = b[p].btn; ped_walk = b[p].walk;
            if (p == 6) cnt0 = m_count;
            for (int i = 0; i < b[p].len; i++) begin
                step();
                n_total++;
                if ({ped_req, btn_clean, press_count} !== {m_req, m_clean, CNT_W'(m_count)})
                    $display("FAIL lockout_b got req=%0b clean=%0b cnt=%0d want req=%0b clean=%0b cnt=%0d",
                             ped_req, btn_clean, press_count, m_req, m_clean, m_count);
                else n_pass++;
            end
            if (p == 6) begin
                n_total++;
                if ({ped_req, press_count} !== {1'b1, CNT_W'(cnt0 + 1)})
                    $display("FAIL lockout_late_press got req=%0b cnt=%0d want req=1 cnt=%0d",
                             ped_req, press_count, cnt0 + 1);
                else n_pass++;
            end
        end
        btn_raw = 1'b0; ped_walk = 1'b1;
        repeat (2) step();
        ped_walk = 1'b0;
        repeat (25) step();
    endtask

    task automatic test_reset_and_saturate();
        btn_raw = 1'b1;
        repeat (9) step();
        btn_raw = 1'b0;
        reset = 1'b1;
        step();
        n_total++;
        if ({ped_req, btn_clean, press_count} !== {1'b0, 1'b0, 8'd0})
            $display("FAIL midreset got req=%0b clean=%0b cnt=%0d want req=0 clean=0 cnt=0",
                     ped_req, btn_clean, press_count);
        else n_pass++;
        reset = 1'b0;
        for (int n = 0; n < 256; n++) begin
            for (int i = 0; i < 30; i++) begin
                btn_raw  = (i < 8);
                ped_walk = (i == 8 || i == 9);
                step();
                n_total++;
                if ({ped_req, btn_clean, press_count} !== {m_req, m_clean, CNT_W'(m_count)})
                    $display("FAIL saturate got req=%0b clean=%0b cnt=%0d want req=%0b clean=%0b cnt=%0d",
                             ped_req, btn_clean, press_count, m_req, m_clean, m_count);
                else n_pass++;
            end
        end
        n_total++;
        if (press_count !== 8'd255) $display("FAIL saturate_final got %0d want 255", press_count);
        else n_pass++;
    endtask

    task automatic test_random();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int r = 0; r < 400; r++) begin
            int len = $urandom_range(1, 10);
            btn_raw  = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) ped_walk = ~ped_walk;
            reset = ($urandom_range(0, 150) == 0);
            for (int i = 0; i < len; i++) begin
                step();
                reset = 1'b0;
                n_total++;
                if ({ped_req, btn_clean, press_count} !== {m_req, m_clean, CNT_W'(m_count)})
                    $display("FAIL random got req=%0b clean=%0b cnt=%0d want req=%0b clean=%0b cnt=%0d",
                             ped_req, btn_clean, press_count, m_req, m_clean, m_count);
                else n_pass++;
            end
        end
    endtask

    initial begin
        reset = 1'b1; btn_raw = 1'b0; ped_walk = 1'b0;
        test_reset();
        test_glitch();
        test_held_through_reset();
        test_serve();
        test_merge();
        test_lockout();
        test_reset_and_saturate();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
